// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM multiplexer/demultiplexer pair: default sizes
// and the channel-tag type, so both ends always agree on tag width.
package tdm_pkg;

  localparam int unsigned N_CH_DEF   = 4;
  localparam int unsigned DATA_W_DEF = 8;

  // Smallest width able to index n channels; n is at least 2.
  function automatic int unsigned sel_w(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  localparam int unsigned SEL_W_DEF = sel_w(N_CH_DEF);

  typedef logic [SEL_W_DEF-1:0] ch_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer, and moves the pointer just past each winner.
module rr_arbiter
  import tdm_pkg::*;
#(
  parameter  int unsigned N = N_CH_DEF,
  localparam int unsigned W = sel_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx;
  logic         found;

  // N is a power of two, so the W-bit add wraps the search modulo N for free.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        idx = ptr_q + W'(i);
        if (!found && req[idx]) begin
          found        = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = idx;
        end
      end
    end
    ptr_d = found ? gnt_idx + W'(1) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tdm_mux.sv
// Merges N_CH valid/ready lanes onto one registered, channel-tagged stream,
// serving the lanes in round-robin order.
module tdm_mux
  import tdm_pkg::*;
#(
  parameter  int unsigned N_CH   = N_CH_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned SEL_W  = sel_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, data_d;
  logic [SEL_W-1:0]  out_sel_q;
  logic              load_en, arb_en, granted;
  logic [N_CH-1:0]   gnt;
  logic [SEL_W-1:0]  gnt_idx;

  assign load_en = !out_valid_q || out_ready;
  // Gating with rst keeps any handshake from completing during reset.
  assign arb_en  = load_en && !rst;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign granted  = |gnt;
  assign in_ready = gnt;

  always_comb begin
    data_d = in_data[int'(gnt_idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (granted) begin
      out_valid_q <= 1'b1;
      out_data_q  <= data_d;
      out_sel_q   <= gnt_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_tdm_mux.sv
// Bench for tdm_mux: directed vector table for the documented scenarios, then
// randomized traffic against a behavioural round-robin model.
module tb_tdm_mux;
  import tdm_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  ch_tag_t       out_sel;
  logic          out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  tdm_mux #(.N_CH(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [1:0]  e_sel;
    logic [7:0]  e_od;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs mid-cycle, check the combinational ready, then check the
  // registered outputs just after the next rising edge.
  task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d,
                      input logic ordy, input logic [3:0] e_rdy, input logic e_ov,
                      input logic [1:0] e_sel, input logic [7:0] e_od, input string tag);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
    if (e_ov || r) begin
      chk({tag, " out_sel"},  32'(out_sel),  32'(e_sel));
      chk({tag, " out_data"}, 32'(out_data), 32'(e_od));
    end else begin
      chk({tag, " held out_data"}, 32'(out_data), 32'(e_od));
    end
  endtask

  // Behavioural model state
  int        m_ptr;
  bit        m_ov;
  int        m_sel;
  bit [7:0]  m_od;

  initial begin
    logic [31:0] dflt, drain;
    dflt  = 32'hA3A2A1A0;
    drain = 32'hA35CA1A0;
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

    //            r  v      d      ordy rdy     ov  sel  od
    vecs.push_back('{1, 4'hF, dflt,  1, 4'b0000, 0, 0, 8'h00}); // reset
    vecs.push_back('{1, 4'hF, dflt,  1, 4'b0000, 0, 0, 8'h00});
    vecs.push_back('{0, 4'hF, dflt,  1, 4'b0001, 1, 0, 8'hA0}); // rotation
    vecs.push_back('{0, 4'hF, dflt,  1, 4'b0010, 1, 1, 8'hA1});
    vecs.push_back('{0, 4'hF, dflt,  1, 4'b0100, 1, 2, 8'hA2});
    vecs.push_back('{0, 4'hF, dflt,  1, 4'b1000, 1, 3, 8'hA3});
    vecs.push_back('{0, 4'hF, dflt,  1, 4'b0001, 1, 0, 8'hA0});
    vecs.push_back('{0, 4'h8, dflt,  1, 4'b1000, 1, 3, 8'hA3}); // sparse ch3
    vecs.push_back('{0, 4'h2, dflt,  1, 4'b0010, 1, 1, 8'hA1}); // wrap, skip ch0
    vecs.push_back('{0, 4'hF, dflt,  0, 4'b0000, 1, 1, 8'hA1}); // backpressure
    vecs.push_back('{0, 4'hF, dflt,  0, 4'b0000, 1, 1, 8'hA1});
    vecs.push_back('{0, 4'hF, dflt,  0, 4'b0000, 1, 1, 8'hA1});
    vecs.push_back('{0, 4'hF, dflt,  1, 4'b0100, 1, 2, 8'hA2}); // pop + grant
    vecs.push_back('{0, 4'h4, drain, 1, 4'b0100, 1, 2, 8'h5C}); // drain
    vecs.push_back('{0, 4'h0, drain, 1, 4'b0000, 0, 2, 8'h5C});
    vecs.push_back('{0, 4'h0, drain, 1, 4'b0000, 0, 2, 8'h5C});
    vecs.push_back('{0, 4'h1, dflt,  1, 4'b0001, 1, 0, 8'hA0}); // load, then stall
    vecs.push_back('{0, 4'hF, dflt,  0, 4'b0000, 1, 0, 8'hA0});
    vecs.push_back('{1, 4'hF, dflt,  1, 4'b0000, 0, 0, 8'h00}); // reset mid-stream
    vecs.push_back('{0, 4'hF, dflt,  1, 4'b0001, 1, 0, 8'hA0}); // ptr back at 0

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].ordy, vecs[i].e_rdy,
           vecs[i].e_ov, vecs[i].e_sel, vecs[i].e_od, $sformatf("vec%0d", i));
    end

    // Randomized traffic. The last vector left the pointer at 1 with ch0 loaded.
    m_ptr = 1; m_ov = 1; m_sel = 0; m_od = 8'hA0;
    for (int c = 0; c < 500; c++) begin
      logic        r, ordy;
      logic [3:0]  v;
      logic [31:0] d;
      logic [3:0]  e_rdy;
      int          g;
      r    = ($urandom_range(0, 40) == 0);
      v    = 4'($urandom);
      d    = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      e_rdy = '0;
      g = -1;
      if (!r && (!m_ov || ordy)) begin
        for (int k = 0; k < N; k++) begin
          int ch;
          ch = (m_ptr + k) % N;
          if (g < 0 && v[ch]) g = ch;
        end
        if (g >= 0) e_rdy[g] = 1'b1;
      end
      if (r) begin
        m_ptr = 0; m_ov = 0; m_sel = 0; m_od = 8'h00;
      end else if (g >= 0) begin
        m_ov = 1; m_sel = g; m_od = d[g*8 +: 8]; m_ptr = (g + 1) % N;
      end else if (m_ov && ordy) begin
        m_ov = 0;
      end
      step(r, v, d, ordy, e_rdy, m_ov, 2'(m_sel), m_od, $sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
